// File: rtl/function_arbiter_rr.sv
// Round-robin arbiter sharing one function unit among N four-phase requesters.
// Inputs are asynchronous and synchronized here; every output except busy is registered.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no grant pending; picks the next winner from ptr
// S_START  | sel/go asserted, waiting for done_s to rise
// S_RETURN | go dropped, waiting for done_s to fall
// S_ACK    | acks[g] high (result valid), waiting for req_s[g] to fall
module function_arbiter_rr #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         reqs,
  input  logic                 done,
  output logic [N-1:0]         acks,
  output logic [N-1:0]         sel,
  output logic                 go,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_RETURN = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][N-1:0] req_sync;
  logic [SYNC_STAGES-1:0]        done_sync;
  logic [N-1:0]                  req_s;
  logic                          done_s;

  state_t        state_q, state_d;
  logic [N-1:0]  acks_q, acks_d;
  logic [N-1:0]  sel_q, sel_d;
  logic          go_q, go_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [IW-1:0] win;
  logic          found;
  int            idx;
  logic [N-1:0]  win_oh;
  logic [N-1:0]  grant_oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync  <= '0;
      done_sync <= '0;
    end else begin
      req_sync  <= {req_sync[SYNC_STAGES-2:0], reqs};
      done_sync <= {done_sync[SYNC_STAGES-2:0], done};
    end
  end

  assign req_s  = req_sync[SYNC_STAGES-1];
  assign done_s = done_sync[SYNC_STAGES-1];

  // First set request scanning upward from ptr, wrapping past N-1.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_s[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign win_oh   = N'(1) << win;
  assign grant_oh = N'(1) << grant_q;

  always_comb begin
    state_d = state_q;
    acks_d  = acks_q;
    sel_d   = sel_q;
    go_d    = go_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = win;
          sel_d   = win_oh;
          go_d    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (done_s) begin
          go_d    = 1'b0;
          state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        if (!done_s) begin
          acks_d  = grant_oh;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s[grant_q]) begin
          acks_d  = '0;
          sel_d   = '0;
          ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acks_q  <= '0;
      sel_q   <= '0;
      go_q    <= 1'b0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      acks_q  <= acks_d;
      sel_q   <= sel_d;
      go_q    <= go_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign acks     = acks_q;
  assign sel      = sel_q;
  assign go       = go_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule
